// File: rtl/hsio_share_pkg.sv
// Shared types and constants for the HSIO pad-sharing controller.
// Also holds the helper that converts a one-hot grant to a requester index.
package hsio_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_e;

    localparam int TURN_W = 4;  // TURNAROUND up to 15
    localparam int HOLD_W = 8;  // MAX_HOLD up to 255
    localparam int IDX_W  = 3;  // up to 8 requesters

    function automatic logic [IDX_W-1:0] oh2idx(input logic [7:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hsio_rr_pick.sv
// Combinational round-robin picker.
// Returns the first active request at or above the pointer, wrapping to index 0.
module hsio_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] src;
    logic             found;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_upper
        assign upper[gi] = req_i[gi] && (gi >= int'(ptr_i));
    end

    // Prefer requests at or above the pointer; fall back to the wrapped set.
    always_comb begin
        onehot_o = '0;
        found    = 1'b0;
        src      = (|upper) ? upper : req_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (src[i] && !found) begin
                onehot_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/hsio_pad_share_ctrl.sv
// Time-shares one bidirectional HSIO pad between N_REQ fabric requesters.
// Round-robin grants, hold-time preemption, forced tristate gap between owners.
module hsio_pad_share_ctrl
    import hsio_share_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int TURNAROUND = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tx_do,
    input  logic [N_REQ-1:0] tx_oe,
    output logic [N_REQ-1:0] gnt,
    output logic             rx_di,
    output logic             pad_do,
    output logic             pad_dt,
    input  logic             pad_di
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TURN_W-1:0]  turn_q, turn_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               pad_do_q, pad_do_d;
    logic               pad_dt_q, pad_dt_d;
    logic               rx_di_q;

    logic [N_REQ-1:0]   pick_oh;
    logic               pick_valid;
    logic [IDX_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               own_req, own_do, own_oe, other_req, exit_own;

    hsio_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .valid_o  (pick_valid)
    );

    // The grant register is one-hot, so masking selects the owner's signals.
    assign own_req   = |(req & gnt_q);
    assign own_do    = |(tx_do & gnt_q);
    assign own_oe    = |(tx_oe & gnt_q);
    assign other_req = |(req & ~gnt_q);
    assign owner_idx = oh2idx(8'(gnt_q));
    assign next_ptr  = (owner_idx == IDX_W'(N_REQ - 1)) ? '0 : PTR_W'(owner_idx + 3'd1);
    assign exit_own  = !own_req || ((hold_q >= HOLD_W'(MAX_HOLD - 1)) && other_req);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        ptr_d    = ptr_q;
        pad_do_d = pad_do_q;
        pad_dt_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = pick_oh;
                    hold_d  = '0;
                end
            end
            OWN: begin
                pad_do_d = own_do;
                if (exit_own) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    turn_d  = TURN_W'(TURNAROUND - 1);
                    ptr_d   = next_ptr;
                end else begin
                    pad_dt_d = ~own_oe;
                    if (hold_q != HOLD_W'(MAX_HOLD)) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - 1'b1;
                end else if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = pick_oh;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            ptr_q    <= '0;
            pad_do_q <= 1'b0;
            pad_dt_q <= 1'b1;
            rx_di_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            ptr_q    <= ptr_d;
            pad_do_q <= pad_do_d;
            pad_dt_q <= pad_dt_d;
            rx_di_q  <= pad_di;
        end
    end

    assign gnt    = gnt_q;
    assign rx_di  = rx_di_q;
    assign pad_do = pad_do_q;
    assign pad_dt = pad_dt_q;

endmodule

// File: tb/tb_hsio_pad_share_ctrl.sv
// Self-checking bench for hsio_pad_share_ctrl: vector table, corner sequences,
// and randomized traffic against an ownership/gap reference model.
module tb_hsio_pad_share_ctrl;

    localparam int N  = 2;
    localparam int T  = 2;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] tx_do = '0;
    logic [N-1:0] tx_oe = '0;
    logic         pad_di = 1'b0;
    logic [N-1:0] gnt;
    logic         rx_di, pad_do, pad_dt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hsio_pad_share_ctrl #(
        .N_REQ      (N),
        .TURNAROUND (T),
        .MAX_HOLD   (MH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .tx_do  (tx_do),
        .tx_oe  (tx_oe),
        .gnt    (gnt),
        .rx_di  (rx_di),
        .pad_do (pad_do),
        .pad_dt (pad_dt),
        .pad_di (pad_di)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] tdo;
        logic [1:0] toe;
        logic       di;
        logic [1:0] gnt;
        logic       dt;
        logic       dout;
        logic       rx;
    } vec_t;

    vec_t vecs [13];

    // Reference model: who owns the pad, for how many cycles, and the gap left.
    int         m_owner;
    int         m_age;
    int         m_gap;
    int         m_ptr;
    logic       m_dt, m_do, m_rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; tx_do = '0; tx_oe = '0; pad_di = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0;
        m_dt = 1'b1; m_do = 1'b0; m_rx = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] r, input logic [1:0] d,
                              input logic [1:0] oe, input logic di);
        logic [1:0] others;
        m_rx = di;
        if (m_owner >= 0) begin
            others = r;
            others[m_owner] = 1'b0;
            m_do = d[m_owner];
            if (!r[m_owner] || (m_age >= MH && others != 2'b00)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = T;
                m_dt    = 1'b1;
            end else begin
                m_dt = !oe[m_owner];
                m_age++;
            end
        end else begin
            m_dt = 1'b1;
            if (m_gap > 1) begin
                m_gap--;
            end else begin
                m_gap = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_age   = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [1:0] m_gnt();
        logic [1:0] g;
        g = 2'b00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    initial begin
        int c;
        int pos;
        logic [1:0] expg;

        vecs[0]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'b11, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 2'b10, 2'b10, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};

        // Reset state and idle hold.
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_dt", 32'(pad_dt), 32'h1);
        chk("rst_do", 32'(pad_do), 32'h0);
        chk("rst_rx", 32'(rx_di), 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_dt", 32'(pad_dt), 32'h1);
        end
        $display("[TB] idle hold: 20 cycles checked");

        // Vector table: grant latency, pad drive, release and turnaround gap.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            req = vecs[i].req; tx_do = vecs[i].tdo; tx_oe = vecs[i].toe; pad_di = vecs[i].di;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_dt", i), 32'(pad_dt), 32'(vecs[i].dt));
            chk($sformatf("vec%0d_do", i), 32'(pad_do), 32'(vecs[i].dout));
            chk($sformatf("vec%0d_rx", i), 32'(rx_di), 32'(vecs[i].rx));
            $display("[TB] vec %0d req=%b gnt=%b pad_dt=%b pad_do=%b", i, req, gnt, pad_dt, pad_do);
        end

        // Both held: 16-cycle grants, 2-cycle gaps, alternating owners.
        do_reset();
        req = 2'b11;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            pos  = (c - 1) % (MH + T);
            expg = (pos < MH) ? ((((c - 1) / (MH + T)) % 2) == 1 ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("alt_c%0d", c), 32'(gnt), 32'(expg));
        end
        $display("[TB] alternation: 60 cycles checked");

        // Lone requester never preempted.
        do_reset();
        req = 2'b01;
        for (c = 1; c <= 100; c++) begin
            @(negedge clk);
            chk("lone_gnt", 32'(gnt), 32'h1);
        end
        $display("[TB] lone owner: 100 cycles checked");

        // Asynchronous reset while requester 1 owns the pad, pointer at 1.
        do_reset();
        req = 2'b01; tx_oe = 2'b11;
        @(negedge clk);
        req = 2'b10;
        repeat (3) @(negedge clk);
        chk("arst_pre_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("arst_pre_dt", 32'(pad_dt), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dt", 32'(pad_dt), 32'h1);
        chk("arst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        chk("arst_ptr0", 32'(gnt), 32'h1);
        $display("[TB] async reset mid-grant checked");

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
            end
            tx_do  = 2'($urandom);
            tx_oe  = 2'($urandom);
            pad_di = 1'($urandom);
            model_step(req, tx_do, tx_oe, pad_di);
            @(negedge clk);
            chk("rnd_gnt", 32'(gnt), 32'(m_gnt()));
            chk("rnd_dt", 32'(pad_dt), 32'(m_dt));
            chk("rnd_do", 32'(pad_do), 32'(m_do));
            chk("rnd_rx", 32'(rx_di), 32'(m_rx));
        end
        $display("[TB] random traffic: 800 cycles checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
